// File: rtl/ssd_scanner.sv
// ssd_scanner: time-multiplexed four-digit seven-segment display driver.
// Each slot is CLK_DIV cycles long. The first BLANK_CYCLES cycles of a slot keep
// every digit dark so the previous digit does not ghost onto the next one.
// All four codes are captured as one snapshot at the start of each frame.
// The overflow request is turned into a blinking LED.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  scan enable; low = dark display, scan parked at slot 0
//   C0..C3              active-low segment codes, C0 = rightmost digit
//   overflow_led        overflow request
//   seg, an             registered segment bus / digit enables, active-low
//   led_out             registered blinking overflow LED, active-high
module ssd_scanner #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_TICKS  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] C0,
  input  logic [6:0] C1,
  input  logic [6:0] C2,
  input  logic [6:0] C3,
  input  logic       overflow_led,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       led_out
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [6:0]       snap [4];
  logic [BLK_W-1:0] blink_cnt;
  logic             prev_req;

  logic tick;
  logic load;
  logic in_blank;

  assign tick = en && (div_cnt == DIV_W'(CLK_DIV - 1));
  // A frame starts when slot 0 begins; the codes are captured then.
  assign load = en && (div_cnt == '0) && (idx == 2'd0);

  // A zero-length blank interval would make the compare trivially false.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (div_cnt < DIV_W'(BLANK_CYCLES));
  end

  // Scan counters, snapshot and pin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= 2'd0;
      for (int i = 0; i < 4; i++) snap[i] <= 7'h7F;
      an      <= 4'b1111;
      seg     <= 7'h7F;
    end else begin
      if (!en) begin
        div_cnt <= '0;
        idx     <= 2'd0;
      end else if (tick) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (load) begin
        snap[0] <= C0;
        snap[1] <= C1;
        snap[2] <= C2;
        snap[3] <= C3;
      end

      // Pins follow the pre-edge state, so on a load cycle seg shows the old
      // snapshot. With BLANK_CYCLES >= 1 that cycle is blanked anyway.
      if (!en || in_blank) begin
        an  <= 4'b1111;
        seg <= 7'h7F;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= snap[idx];
      end
    end
  end

  // Overflow blinker: a fresh request lights the LED at once and restarts the
  // phase. After that the LED toggles every BLINK_TICKS slot ticks, so it
  // pauses along with the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      prev_req  <= 1'b0;
      led_out   <= 1'b0;
    end else begin
      prev_req <= overflow_led;
      if (!overflow_led) begin
        blink_cnt <= '0;
        led_out   <= 1'b0;
      end else if (!prev_req) begin
        blink_cnt <= '0;
        led_out   <= 1'b1;
      end else if (tick) begin
        if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
          blink_cnt <= '0;
          led_out   <= ~led_out;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_scanner.sv
// Bench for ssd_scanner with CLK_DIV=8, BLINK_TICKS=3. Instance a uses
// BLANK_CYCLES=2 and instance b uses BLANK_CYCLES=0. Both share the inputs.
module tb_ssd_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ovf = 1'b0;
  logic [6:0] c0 = 7'h7F, c1 = 7'h7F, c2 = 7'h7F, c3 = 7'h7F;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       led_a, led_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ssd_scanner #(.CLK_DIV(8), .BLANK_CYCLES(2), .BLINK_TICKS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en),
    .C0(c0), .C1(c1), .C2(c2), .C3(c3),
    .overflow_led(ovf), .seg(seg_a), .an(an_a), .led_out(led_a)
  );

  ssd_scanner #(.CLK_DIV(8), .BLANK_CYCLES(0), .BLINK_TICKS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .C0(c0), .C1(c1), .C2(c2), .C3(c3),
    .overflow_led(ovf), .seg(seg_b), .an(an_b), .led_out(led_b)
  );

  // Display windows for instance a: pins after edges first..last. Every other
  // edge is expected blank.
  typedef struct {
    int         first;
    int         last;
    logic [3:0] an;
    logic [6:0] seg;
  } win_t;

  typedef struct {
    int         e;
    logic [3:0] an_a;
    logic [6:0] seg_a;
    logic       led;
    logic [3:0] an_b;
    logic [6:0] seg_b;
  } exp_t;

  win_t win [10];
  exp_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t x;
    int   slot;

    win[0] = '{2, 7, 4'b1110, 7'h40};
    win[1] = '{10, 15, 4'b1101, 7'h79};
    win[2] = '{18, 23, 4'b1011, 7'h24};
    win[3] = '{26, 31, 4'b0111, 7'h30};
    win[4] = '{34, 39, 4'b1110, 7'h40};
    win[5] = '{42, 47, 4'b1101, 7'h12};
    win[6] = '{50, 55, 4'b1011, 7'h24};
    win[7] = '{58, 63, 4'b0111, 7'h30};
    win[8] = '{66, 71, 4'b1110, 7'h40};
    win[9] = '{74, 79, 4'b1101, 7'h12};

    // Reset with arbitrary inputs.
    rst_n = 1'b0;
    en  = 1'b1;
    ovf = 1'b1;
    c0 = 7'($urandom); c1 = 7'($urandom); c2 = 7'($urandom); c3 = 7'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_an_a", an_a, 4'b1111);
    chk("reset_seg_a", seg_a, 7'h7F);
    chk("reset_led_a", led_a, 1'b0);
    chk("reset_an_b", an_b, 4'b1111);
    chk("reset_seg_b", seg_b, 7'h7F);

    // Main scan and blink run, edges 0..79.
    c0 = 7'h40; c1 = 7'h79; c2 = 7'h24; c3 = 7'h30;
    en = 1'b1;
    ovf = 1'b1;
    rst_n = 1'b1;
    for (int e = 0; e < 80; e++) begin
      if (e == 5)  c1 = 7'h12;
      if (e == 48) ovf = 1'b0;
      if (e == 58) ovf = 1'b1;

      x.e = e;
      x.an_a = 4'b1111;
      x.seg_a = 7'h7F;
      for (int w = 0; w < 10; w++)
        if (e >= win[w].first && e <= win[w].last) begin
          x.an_a = win[w].an;
          x.seg_a = win[w].seg;
        end
      if (e < 48)      x.led = (((e + 1) / 24) % 2) == 0;
      else if (e < 58) x.led = 1'b0;
      else             x.led = (e < 79);
      slot = (e / 8) % 4;
      x.an_b = ~(4'b0001 << slot);
      case (slot)
        0:       x.seg_b = (e == 0) ? 7'h7F : 7'h40;
        1:       x.seg_b = (e < 40) ? 7'h79 : 7'h12;
        2:       x.seg_b = 7'h24;
        default: x.seg_b = 7'h30;
      endcase
      sb.push_back(x);

      step();
      x = sb.pop_front();
      chk($sformatf("e%0d_an_a", x.e), an_a, x.an_a);
      chk($sformatf("e%0d_seg_a", x.e), seg_a, x.seg_a);
      chk($sformatf("e%0d_led_a", x.e), led_a, x.led);
      chk($sformatf("e%0d_an_b", x.e), an_b, x.an_b);
      chk($sformatf("e%0d_seg_b", x.e), seg_b, x.seg_b);
      @(negedge clk);
    end
    chk("scoreboard_empty", sb.size(), 0);

    // Enable gating: restart from reset and drop en at edge 13.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    ovf = 1'b1;
    for (int e = 0; e < 13; e++) begin
      step();
      @(negedge clk);
    end
    chk("en_pre_an_a", an_a, 4'b1101);
    chk("en_pre_seg_a", seg_a, 7'h12);
    en = 1'b0;
    for (int e = 13; e < 17; e++) begin
      if (e == 14) c0 = 7'h19;
      step();
      chk($sformatf("en_off%0d_an_a", e), an_a, 4'b1111);
      chk($sformatf("en_off%0d_seg_a", e), seg_a, 7'h7F);
      chk($sformatf("en_off%0d_an_b", e), an_b, 4'b1111);
      @(negedge clk);
    end
    chk("pause_led_a", led_a, 1'b1);
    chk("pause_led_b", led_b, 1'b1);
    en = 1'b1;
    step();   // edge 17: fresh load, still blank on a
    chk("re17_an_a", an_a, 4'b1111);
    chk("re17_an_b", an_b, 4'b1110);
    chk("re17_seg_b_old", seg_b, 7'h40);
    @(negedge clk);
    step();   // edge 18
    chk("re18_an_a", an_a, 4'b1111);
    chk("re18_seg_b", seg_b, 7'h19);
    @(negedge clk);
    step();   // edge 19: first digit visible on a
    chk("re19_an_a", an_a, 4'b1110);
    chk("re19_seg_a", seg_a, 7'h19);

    // Asynchronous reset in the middle of a slot.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an_a", an_a, 4'b1111);
    chk("arst_seg_a", seg_a, 7'h7F);
    chk("arst_led_a", led_a, 1'b0);
    chk("arst_an_b", an_b, 4'b1111);
    chk("arst_seg_b", seg_b, 7'h7F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
